// File: rtl/rgb_fmt_pkg.sv
// Shared definitions for the RGB output formatter.
//   fmt_mode_e   : reduction mode encodings (reserved code behaves as truncate)
//   FMT_LAT      : input-to-output latency in pixel clocks
//   BAYER4       : 4x4 ordered-dither matrix, element index {y, x}
//   bayer_lookup : dither threshold for a given x/y position
package rgb_fmt_pkg;

    typedef enum logic [1:0] {
        MODE_TRUNC  = 2'd0,
        MODE_ROUND  = 2'd1,
        MODE_DITHER = 2'd2,
        MODE_RSVD   = 2'd3
    } fmt_mode_e;

    localparam int unsigned FMT_LAT = 3;

    // Element 0 sits in the low nibble; rows are y, columns are x.
    localparam logic [15:0][3:0] BAYER4 = {
        4'd5, 4'd13, 4'd7,  4'd15,
        4'd9, 4'd1,  4'd11, 4'd3,
        4'd6, 4'd14, 4'd4,  4'd12,
        4'd10, 4'd2, 4'd8,  4'd0
    };

    function automatic logic [3:0] bayer_lookup(input logic [1:0] x, input logic [1:0] y);
        return BAYER4[{y, x}];
    endfunction

endpackage

// File: rtl/rgb_dither_out_if.sv
// Video-in / DAC-out signal bundle for rgb_dither_out.
//   master : video source side (drives pixel, syncs, mode; observes DAC pins)
//   slave  : formatter side
// Signals: av_in, hs_in, vs_in, data_in[3*IN_W], mode[2] in;
//          red_out[R_W], green_out[G_W], blue_out[B_W], av_out, hs_out, vs_out out.
interface rgb_dither_out_if #(
    parameter int unsigned IN_W = 8,
    parameter int unsigned R_W  = 5,
    parameter int unsigned G_W  = 6,
    parameter int unsigned B_W  = 5
) ();
    logic              av_in;
    logic              hs_in;
    logic              vs_in;
    logic [3*IN_W-1:0] data_in;
    logic [1:0]        mode;
    logic [R_W-1:0]    red_out;
    logic [G_W-1:0]    green_out;
    logic [B_W-1:0]    blue_out;
    logic              av_out;
    logic              hs_out;
    logic              vs_out;

    modport master (
        output av_in, hs_in, vs_in, data_in, mode,
        input  red_out, green_out, blue_out, av_out, hs_out, vs_out
    );

    modport slave (
        input  av_in, hs_in, vs_in, data_in, mode,
        output red_out, green_out, blue_out, av_out, hs_out, vs_out
    );
endinterface

// File: rtl/rgb_chan_quant.sv
// One colour channel, pipeline stages 2 and 3.
//   v    : stage-1 channel value      d    : stage-1 Bayer threshold
//   mode : stage-1 latched mode       keep : stage-2 active-video (0 blanks)
//   q    : registered OUT_W-bit result
// Stage 2 adds the mode-dependent offset and saturates; stage 3 slices and gates.
module rgb_chan_quant
    import rgb_fmt_pkg::*;
#(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  v,
    input  logic [3:0]       d,
    input  fmt_mode_e        mode,
    input  logic             keep,
    output logic [OUT_W-1:0] q
);
    localparam int unsigned K = IN_W - OUT_W;

    logic [IN_W:0]   sum;
    logic [IN_W-1:0] sat_d;
    logic [IN_W-1:0] sat_q;

    generate
        if (K == 0) begin : g_pass
            // Nothing is dropped, so no offset is ever applied.
            logic unused_ctl;
            assign unused_ctl = ^{d, mode};
            assign sum = {1'b0, v};
        end else begin : g_reduce
            logic [K-1:0] off;
            logic         unused_lsb;

            always_comb begin
                off = '0;
                case (mode)
                    MODE_ROUND:  off[K-1] = 1'b1;
                    MODE_DITHER: off = d[3 -: K];
                    default:     off = '0;
                endcase
            end

            assign sum        = {1'b0, v} + {{(IN_W + 1 - K){1'b0}}, off};
            assign unused_lsb = ^sat_q[K-1:0];
        end
    endgenerate

    assign sat_d = sum[IN_W] ? {IN_W{1'b1}} : sum[IN_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= '0;
            q     <= '0;
        end else begin
            sat_q <= sat_d;
            q     <= keep ? sat_q[IN_W-1:K] : '0;
        end
    end
endmodule

// File: rtl/rgb_dither_out.sv
// Video-out formatter driving a resistor-ladder RGB DAC.
//   clk, rst : pixel clock, asynchronous active-high reset
//   vif      : slave side of rgb_dither_out_if (pixel/syncs/mode in, DAC pins out)
// Stage 1 (here): lane select, Bayer lookup, x/y counters, mode latch.
// Stages 2-3 per channel in rgb_chan_quant; syncs ride a matching delay line.
module rgb_dither_out
    import rgb_fmt_pkg::*;
#(
    parameter int unsigned IN_W   = 8,
    parameter int unsigned R_W    = 5,
    parameter int unsigned G_W    = 6,
    parameter int unsigned B_W    = 5,
    parameter int unsigned R_LANE = 2,
    parameter int unsigned G_LANE = 0,
    parameter int unsigned B_LANE = 1
) (
    input logic             clk,
    input logic             rst,
    rgb_dither_out_if.slave vif
);
    logic [1:0]         x_q, y_q;
    logic               av_prev_q, vs_prev_q;
    fmt_mode_e          mode_q, mode1_q;
    logic [IN_W-1:0]    r1_q, g1_q, b1_q;
    logic [3:0]         d1_q;
    logic [FMT_LAT-1:0] av_dl_q, hs_dl_q, vs_dl_q;
    logic               vs_rise, av_fall;
    logic [R_W-1:0]     red_q;
    logic [G_W-1:0]     green_q;
    logic [B_W-1:0]     blue_q;

    assign vs_rise = vif.vs_in & ~vs_prev_q;
    assign av_fall = ~vif.av_in & av_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q       <= '0;
            y_q       <= '0;
            av_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
            mode_q    <= MODE_TRUNC;
            mode1_q   <= MODE_TRUNC;
            r1_q      <= '0;
            g1_q      <= '0;
            b1_q      <= '0;
            d1_q      <= '0;
            av_dl_q   <= '0;
            hs_dl_q   <= '0;
            vs_dl_q   <= '0;
        end else begin
            av_prev_q <= vif.av_in;
            vs_prev_q <= vif.vs_in;

            // Stage 1 uses counters and mode as they stood before this edge.
            r1_q    <= vif.data_in[R_LANE*IN_W +: IN_W];
            g1_q    <= vif.data_in[G_LANE*IN_W +: IN_W];
            b1_q    <= vif.data_in[B_LANE*IN_W +: IN_W];
            d1_q    <= bayer_lookup(x_q, y_q);
            mode1_q <= mode_q;

            x_q <= vif.av_in ? x_q + 2'd1 : 2'd0;

            // Frame start beats end-of-line when both land on one edge.
            if (vs_rise) begin
                y_q    <= 2'd0;
                mode_q <= fmt_mode_e'(vif.mode);
            end else if (av_fall) begin
                y_q <= y_q + 2'd1;
            end

            av_dl_q <= {av_dl_q[FMT_LAT-2:0], vif.av_in};
            hs_dl_q <= {hs_dl_q[FMT_LAT-2:0], vif.hs_in};
            vs_dl_q <= {vs_dl_q[FMT_LAT-2:0], vif.vs_in};
        end
    end

    // keep is the stage-2 copy of av, so blanking lines up with stage 3.
    rgb_chan_quant #(.IN_W(IN_W), .OUT_W(R_W)) u_red (
        .clk  (clk),
        .rst  (rst),
        .v    (r1_q),
        .d    (d1_q),
        .mode (mode1_q),
        .keep (av_dl_q[1]),
        .q    (red_q)
    );

    rgb_chan_quant #(.IN_W(IN_W), .OUT_W(G_W)) u_green (
        .clk  (clk),
        .rst  (rst),
        .v    (g1_q),
        .d    (d1_q),
        .mode (mode1_q),
        .keep (av_dl_q[1]),
        .q    (green_q)
    );

    rgb_chan_quant #(.IN_W(IN_W), .OUT_W(B_W)) u_blue (
        .clk  (clk),
        .rst  (rst),
        .v    (b1_q),
        .d    (d1_q),
        .mode (mode1_q),
        .keep (av_dl_q[1]),
        .q    (blue_q)
    );

    assign vif.red_out   = red_q;
    assign vif.green_out = green_q;
    assign vif.blue_out  = blue_q;
    assign vif.av_out    = av_dl_q[FMT_LAT-1];
    assign vif.hs_out    = hs_dl_q[FMT_LAT-1];
    assign vif.vs_out    = vs_dl_q[FMT_LAT-1];
endmodule
